alien_collision_ctrl: RTL

- Pixel-rate collision and life-cycle controller sitting directly downstream of the alien block.
- Consumes the merged alien drawing request together with the player and shot drawing requests. It produces the alien_died strobe fed back into the alien block and the player_died strobe fed into the alien and player movers.
- Owns the player death/respawn state machine, the lives counter and the score.

---
 rtl/alien_pkg.sv | 17 +
 rtl/frame_counter.sv | 25 ++
 rtl/alien_collision_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alien_pkg.sv
// alien_pkg: shared life-cycle state type, widths and score helper for the alien collision controller.
package alien_pkg;

    typedef enum logic [1:0] {ALIVE, DYING, GAME_OVER} life_state_t;

    localparam int LIVES_W = 3;
    localparam int SCORE_W = 14;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input int unsigned b,
                                                   input int unsigned max);
        int unsigned s;
        s = 32'(a) + b;
        return (s > max) ? SCORE_W'(max) : SCORE_W'(s);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// frame_counter: counts startOfFrame-qualified increments, clears on demand, flags terminal count TERM.
module frame_counter #(
    parameter int TERM = 59
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int W = (TERM > 0) ? $clog2(TERM + 1) : 1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            r_cnt <= '0;
        else if (inc)
            r_cnt <= r_cnt + 1'b1;
    end

    assign tc = (r_cnt == W'(TERM));

endmodule

// File: rtl/alien_collision_ctrl.sv
// alien_collision_ctrl: pixel-rate kill/death detection, player life-cycle FSM, lives and score.
// Optional INVULN_EN adds a post-respawn invulnerability window.
module alien_collision_ctrl
    import alien_pkg::*;
#(
    parameter int START_LIVES   = 3,
    parameter int DEATH_FRAMES  = 60,
`ifdef INVULN_EN
    parameter int INVULN_FRAMES = 90,
`endif
    parameter int ALIEN_POINTS  = 250,
    parameter int SCORE_MAX     = 9999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               restart,
    input  logic               player_dr,
    input  logic               alien_dr,
    input  logic               shot_dr,
    output logic               alien_died,
    output logic               shot_hit,
    output logic               player_died,
    output logic               player_respawn,
    output logic               game_over,
    output logic               invulnerable,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score
);

    life_state_t        r_state;
    logic               r_kill_armed;
    logic               r_death_armed;
    logic               r_shot_hit;
    logic               r_player_died;
    logic               r_player_respawn;
    logic [LIVES_W-1:0] r_lives;
    logic [SCORE_W-1:0] r_score;
    logic               w_hit;
    logic               w_invuln;
    logic               w_restart;
    logic               w_dying_tc;
    logic               w_dying_end;
    logic               w_respawn;

    // Zero latency: the alien block uses this to drop the alien under the current pixel.
    assign alien_died  = alien_dr & shot_dr & r_kill_armed & (r_state != GAME_OVER);
    assign w_hit       = alien_dr & player_dr & r_death_armed & (r_state == ALIVE) & ~w_invuln;
    assign w_restart   = restart & (r_state == GAME_OVER);
    assign w_dying_end = startOfFrame & (r_state == DYING) & w_dying_tc;
    assign w_respawn   = w_dying_end & (r_lives != '0);

    frame_counter #(.TERM(DEATH_FRAMES - 1)) u_death_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_hit | w_restart),
        .inc   (startOfFrame & (r_state == DYING) & ~w_dying_tc),
        .tc    (w_dying_tc)
    );

`ifdef INVULN_EN
    logic r_invuln;
    logic w_invuln_tc;

    frame_counter #(.TERM(INVULN_FRAMES - 1)) u_invuln_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_respawn | w_restart),
        .inc   (startOfFrame & r_invuln & ~w_invuln_tc),
        .tc    (w_invuln_tc)
    );

    always_ff @(posedge clk) begin
        if (reset || w_restart)
            r_invuln <= 1'b0;
        else if (w_respawn)
            r_invuln <= 1'b1;
        else if (startOfFrame && w_invuln_tc)
            r_invuln <= 1'b0;
    end

    assign w_invuln = r_invuln;
`else
    assign w_invuln = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_state          <= ALIVE;
            r_lives          <= LIVES_W'(START_LIVES);
            r_score          <= '0;
            r_kill_armed     <= 1'b1;
            r_death_armed    <= 1'b1;
            r_shot_hit       <= 1'b0;
            r_player_died    <= 1'b0;
            r_player_respawn <= 1'b0;
        end else begin
            r_shot_hit       <= alien_died;
            r_player_died    <= w_hit;
            r_player_respawn <= w_respawn;
            r_kill_armed     <= startOfFrame ? 1'b1 : (alien_died ? 1'b0 : r_kill_armed);
            if (alien_died)
                r_score <= sat_add(r_score, ALIEN_POINTS, SCORE_MAX);
            case (r_state)
                ALIVE: begin
                    if (w_hit) begin
                        r_state       <= DYING;
                        r_lives       <= (r_lives == '0) ? '0 : r_lives - 1'b1;
                        r_death_armed <= 1'b0;
                    end else if (startOfFrame) begin
                        r_death_armed <= 1'b1;
                    end
                end
                DYING: begin
                    if (w_dying_end) begin
                        r_state       <= (r_lives == '0) ? GAME_OVER : ALIVE;
                        r_death_armed <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign shot_hit       = r_shot_hit;
    assign player_died    = r_player_died;
    assign player_respawn = r_player_respawn;
    assign game_over      = (r_state == GAME_OVER);
    assign invulnerable   = w_invuln;
    assign lives          = r_lives;
    assign score          = r_score;

endmodule
